fft_frame_sequencer: RTL

// Frame-level controller for the 256-point fft_top core. It requests a transform, loads
// N_POINTS samples from the ADC sample stream, and waits for fft_done. It then reads N_OUT

---
 rtl/fft_frame_sequencer_if.sv | 39 +++
 rtl/fft_frame_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer_if.sv
// Bundle of the sample stream, fft_top core handshake and bin output path used by
// fft_frame_sequencer. master = sequencer side, slave = environment side.
interface fft_frame_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12
);
    // Sample stream: a transfer occurs on every clk where samp_valid && samp_ready;
    // samp_data must be stable while samp_valid is high, samp_ready never waits on samp_valid.
    logic                  samp_valid;
    logic [DATA_WIDTH-1:0] samp_data;
    logic                  samp_ready;

    logic                  fft_start;
    logic                  fft_tready;
    logic [DATA_WIDTH-1:0] fft_data_in;
    logic [ADDR_WIDTH-1:0] fft_addr_in;
    logic                  fft_data_in_en;
    logic                  fft_done;
    logic                  fft_rd_en;
    logic [ADDR_WIDTH-1:0] fft_rd_addr;
    logic [DATA_WIDTH-1:0] fft_rd_data;

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_bin;
    logic                  out_last;

    modport master (
        input  samp_valid, samp_data, fft_tready, fft_done, fft_rd_data,
        output samp_ready, fft_start, fft_data_in, fft_addr_in, fft_data_in_en,
               fft_rd_en, fft_rd_addr, out_valid, out_data, out_bin, out_last
    );

    modport slave (
        output samp_valid, samp_data, fft_tready, fft_done, fft_rd_data,
        input  samp_ready, fft_start, fft_data_in, fft_addr_in, fft_data_in_en,
               fft_rd_en, fft_rd_addr, out_valid, out_data, out_bin, out_last
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame controller for the fft_top core: request, load N_POINTS samples, wait for done,
// stream N_OUT bins out, with a watchdog on the core handshake and transform states.
module fft_frame_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12,
    parameter int N_POINTS   = 256,
    parameter int N_OUT      = 128,
    parameter int TO_CYCLES  = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 trig,
    fft_frame_sequencer_if.master bus,
    output logic                 busy,
    output logic [15:0]          frame_cnt,
    output logic                 err_timeout,
    output logic [2:0]           state_dbg
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_LOAD = 3'd2,
        S_CALC = 3'd3,
        S_READ = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_WR = ADDR_WIDTH'(N_POINTS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_RD = ADDR_WIDTH'(N_OUT - 1);
    localparam logic [15:0]           WD_LAST = 16'(TO_CYCLES - 1);

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [15:0]           wd_cnt;
    logic                  samp_fire;
    logic                  wd_expire;

    assign samp_fire = bus.samp_valid & bus.samp_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // wd_cnt holds the number of cycles already spent in the current REQ/CALC visit.
    always_comb begin
        next_state = state;
        wd_expire  = 1'b0;
        case (state)
            S_IDLE: if (run || trig) next_state = S_REQ;
            S_REQ: begin
                if (bus.fft_tready) next_state = S_LOAD;
                else if (wd_cnt == WD_LAST) begin
                    next_state = S_IDLE;
                    wd_expire  = 1'b1;
                end
            end
            S_LOAD: if (samp_fire && wr_cnt == LAST_WR) next_state = S_CALC;
            S_CALC: begin
                if (bus.fft_done) next_state = S_READ;
                else if (wd_cnt == WD_LAST) begin
                    next_state = S_IDLE;
                    wd_expire  = 1'b1;
                end
            end
            S_READ: if (rd_cnt == LAST_RD) next_state = S_DONE;
            S_DONE: next_state = run ? S_REQ : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        bus.fft_start  = (state == S_REQ);
        bus.samp_ready = (state == S_LOAD);
        bus.fft_rd_en  = (state == S_READ);
        busy           = (state != S_IDLE);
        state_dbg      = state;
    end

    assign bus.fft_rd_addr = rd_cnt;
    // Read data arrives from the core one cycle after the strobe, aligned with out_valid.
    assign bus.out_data    = bus.out_valid ? bus.fft_rd_data : {DATA_WIDTH{1'b0}};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt             <= '0;
            rd_cnt             <= '0;
            wd_cnt             <= '0;
            bus.fft_data_in_en <= 1'b0;
            bus.fft_data_in    <= '0;
            bus.fft_addr_in    <= '0;
            bus.out_valid      <= 1'b0;
            bus.out_bin        <= '0;
            bus.out_last       <= 1'b0;
            frame_cnt          <= '0;
            err_timeout        <= 1'b0;
        end else begin
            bus.fft_data_in_en <= samp_fire;
            if (samp_fire) begin
                bus.fft_data_in <= bus.samp_data;
                bus.fft_addr_in <= wr_cnt;
                wr_cnt          <= wr_cnt + 1'b1;
            end else if (state != S_LOAD) begin
                wr_cnt <= '0;
            end

            rd_cnt       <= (state == S_READ) ? rd_cnt + 1'b1 : '0;
            bus.out_valid <= (state == S_READ);
            bus.out_bin   <= rd_cnt;
            bus.out_last  <= (state == S_READ) && (rd_cnt == LAST_RD);

            if (next_state != state) wd_cnt <= '0;
            else if (state == S_REQ || state == S_CALC) wd_cnt <= wd_cnt + 1'b1;

            if (state == S_DONE) frame_cnt <= frame_cnt + 1'b1;
            if (wd_expire) err_timeout <= 1'b1;
        end
    end
endmodule
